// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Fetch entries pair an instruction word with the PC it was fetched from.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are word granular, so the low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch FIFO of fetch entries; flush empties it and wins over push/pop.
// An empty queue presents an all-zero head so downstream sees a clean bubble.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    // Pointer and occupancy next-state; a push into a full queue is only legal alongside a pop.
    always_comb begin
        pop_ok_s  = pop && (count_q != {CW{1'b0}});
        push_ok_s = push && ((count_q != FULL_CNT) || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(ADDR_W + INSTR_W){1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Head presentation; zero when nothing is queued.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (count_q == {CW{1'b0}}) begin
            head.pc    = {ADDR_W{1'b0}};
            head.instr = NOP_INSTR;
        end else begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word requests, buffers
// responses and hands one instruction per cycle to the core; redirects flush.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int SW  = CW + 1;
    localparam logic [SW-1:0] BUDGET = SW'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     q_count_s;
    logic              accept_s, rsp_s, push_s, pop_s;
    fetch_entry_t      head_s, push_entry_s;

    // Request gating: queued plus outstanding words never exceed the queue depth.
    always_comb begin
        imem_req     = !rst && !redirect &&
                       (({1'b0, q_count_s} + {1'b0, inflight_q}) < BUDGET);
        accept_s     = imem_req && imem_ready;
        rsp_s        = imem_rvalid && (inflight_q != {CW{1'b0}});
        push_s       = rsp_s && (drop_cnt_q == {CW{1'b0}}) && !redirect;
        instr_valid  = (q_count_s != {CW{1'b0}});
        pop_s        = instr_valid && instr_ready && !redirect;
        push_entry_s = '{pc: resp_pc_q, instr: imem_rdata};
    end

    // PC and in-flight bookkeeping; a redirect re-arms drop_cnt with every word still owed.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            inflight_d = inflight_q - {{(CW-1){1'b0}}, rsp_s};
            drop_cnt_d = inflight_q - {{(CW-1){1'b0}}, rsp_s};
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (rsp_s && (drop_cnt_q != {CW{1'b0}})) begin
                drop_cnt_d = drop_cnt_q - CW'(1'b1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            case ({accept_s, rsp_s})
                2'b10:   inflight_d = inflight_q + CW'(1'b1);
                2'b01:   inflight_d = inflight_q - CW'(1'b1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= {CW{1'b0}};
            drop_cnt_q <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (push_entry_s),
        .pop   (pop_s),
        .flush (redirect),
        .count (q_count_s),
        .head  (head_s)
    );

    assign imem_addr = fetch_pc_q;
    assign instr     = head_s.instr;
    assign instr_pc  = head_s.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue-level model of the fetch rules
// is checked every cycle, plus literal expectations for each scenario.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk, rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, instr_valid, instr_ready;
    logic [31:0] redirect_pc, instr, instr_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mem_lat = 1;

    logic        drv_redirect = 1'b0;
    logic [31:0] drv_rpc      = 32'h0;
    logic        drv_rdy      = 1'b1;
    logic        drv_mrdy     = 1'b1;

    // memory environment: accepted addresses with their due cycle
    logic [31:0] mem_addr_q[$];
    int          mem_due[$];

    // model state
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    logic [31:0] exp_fetch, exp_resp;
    int          exp_drop, exp_inflight;

    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_ilog[$];
    int          first_acc, first_valid;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq_pc.delete();
        mq_in.delete();
        mem_addr_q.delete();
        mem_due.delete();
        exp_fetch    = RESET_PC;
        exp_resp     = RESET_PC;
        exp_drop     = 0;
        exp_inflight = 0;
        first_acc    = -1;
        first_valid  = -1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_ready  = 1'b0;
        instr_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs, compare against the model, then advance the model.
    task automatic tick();
        logic        rv, exp_v, exp_req, acc_e;
        logic [31:0] rd;
        redirect    = drv_redirect;
        redirect_pc = drv_rpc;
        instr_ready = drv_rdy;
        imem_ready  = drv_mrdy;
        rv = (mem_addr_q.size() != 0) && (mem_due[0] <= cyc);
        rd = rv ? mem_word(mem_addr_q[0]) : 32'h0;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
        exp_v   = (mq_pc.size() != 0);
        exp_req = !drv_redirect && ((mq_pc.size() + exp_inflight) < DEPTH);
        check("instr_valid", 32'(instr_valid), 32'(exp_v));
        check("instr_pc", instr_pc, exp_v ? mq_pc[0] : 32'h0);
        check("instr", instr, exp_v ? mq_in[0] : 32'h0);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, exp_fetch);

        if (imem_req && imem_ready) begin
            acc_log.push_back(imem_addr);
            mem_addr_q.push_back(imem_addr);
            mem_due.push_back(cyc + mem_lat);
            if (first_acc < 0) first_acc = cyc;
        end
        if (instr_valid && first_valid < 0) first_valid = cyc;
        if (instr_valid && instr_ready && !redirect) begin
            pop_log.push_back(instr_pc);
            pop_ilog.push_back(instr);
        end
        if (rv) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due.pop_front());
        end

        acc_e = exp_req && drv_mrdy;
        if (drv_redirect) begin
            mq_pc.delete();
            mq_in.delete();
            exp_fetch    = {drv_rpc[31:2], 2'b00};
            exp_resp     = {drv_rpc[31:2], 2'b00};
            exp_drop     = exp_inflight - (rv ? 1 : 0);
            exp_inflight = exp_drop;
        end else begin
            if (mq_pc.size() != 0 && drv_rdy) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (rv) begin
                if (exp_drop != 0) begin
                    exp_drop--;
                end else begin
                    mq_pc.push_back(exp_resp);
                    mq_in.push_back(rd);
                    exp_resp = exp_resp + 32'd4;
                end
            end
            if (acc_e) exp_fetch = exp_fetch + 32'd4;
            exp_inflight = exp_inflight + (acc_e ? 1 : 0) - (rv ? 1 : 0);
        end
        drv_redirect = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        drv_redirect = 1'b1;
        drv_rpc      = pc;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);

        // 1: streaming with a 1-cycle memory
        mem_lat = 1; drv_rdy = 1'b1; drv_mrdy = 1'b1;
        apply_reset();
        acc_log.delete(); pop_log.delete();
        run(12);
        check("s1_acc0", acc_log[0], 32'h0000_0000);
        check("s1_acc1", acc_log[1], 32'h0000_0004);
        check("s1_acc2", acc_log[2], 32'h0000_0008);
        check("s1_acc3", acc_log[3], 32'h0000_000C);
        check("s1_latency", 32'(first_valid - first_acc), 32'd2);
        check("s1_pop0", pop_log[0], 32'h0000_0000);
        check("s1_pop1", pop_log[1], 32'h0000_0004);
        check("s1_pop2", pop_log[2], 32'h0000_0008);

        // 2: consumer stalled fills the budget, then drains in order
        drv_rdy = 1'b0;
        apply_reset();
        acc_log.delete(); pop_log.delete();
        run(12);
        check("s2_acc_count", 32'(acc_log.size()), 32'd4);
        check("s2_req_stalled", 32'(imem_req), 32'd0);
        check("s2_head_pc", instr_pc, 32'h0000_0000);
        drv_rdy = 1'b1;
        run(10);
        check("s2_drain0", pop_log[0], 32'h0000_0000);
        check("s2_drain3", pop_log[3], 32'h0000_000C);
        check("s2_resume", pop_log[4], 32'h0000_0010);

        // 3: redirect with three words in flight on a 3-cycle memory
        mem_lat = 3;
        apply_reset();
        run(3);
        check("s3_inflight", 32'(mem_addr_q.size()), 32'd3);
        pop_log.delete(); pop_ilog.delete();
        do_redirect(32'h0000_0100);
        run(15);
        check("s3_first_pc", pop_log[0], 32'h0000_0100);
        check("s3_first_instr", pop_ilog[0], 32'hDEAD_0100);

        // 4: redirect coinciding with a response and a ready consumer
        mem_lat = 1;
        apply_reset();
        run(4);
        check("s4_pre_valid", 32'(instr_valid), 32'd1);
        pop_log.delete();
        do_redirect(32'h0000_0080);
        check("s4_flushed", 32'(instr_valid), 32'd0);
        check("s4_fetch_pc", imem_addr, 32'h0000_0080);
        run(5);
        check("s4_next_pc", pop_log[0], 32'h0000_0080);

        // 5: unaligned target, then PC wrap at the top of the address space
        acc_log.delete();
        do_redirect(32'h0000_0203);
        run(4);
        check("s5_align", acc_log[0], 32'h0000_0200);
        acc_log.delete(); pop_log.delete();
        do_redirect(32'hFFFF_FFF8);
        run(8);
        check("s5_wrap0", acc_log[0], 32'hFFFF_FFF8);
        check("s5_wrap1", acc_log[1], 32'hFFFF_FFFC);
        check("s5_wrap2", acc_log[2], 32'h0000_0000);
        check("s5_pop_wrap", pop_log[2], 32'h0000_0000);

        // 6: asynchronous reset between edges with work queued and outstanding
        mem_lat = 3; drv_rdy = 1'b0;
        apply_reset();
        run(5);
        check("s6_pre_valid", 32'(instr_valid), 32'd1);
        check("s6_pre_inflight", 32'(mem_addr_q.size()), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("s6_async_valid", 32'(instr_valid), 32'd0);
        check("s6_async_req", 32'(imem_req), 32'd0);
        check("s6_async_pc", instr_pc, 32'h0);
        imem_rvalid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv_rdy = 1'b1;
        acc_log.delete();
        run(3);
        check("s6_restart", acc_log[0], RESET_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
